// File: rtl/serial_adder_if.sv
// Operand/result bundle between a controller and the serial adder.
// The controller drives the master side; the adder implements the slave side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder through one addbit cell, LSB first; start->done latency WIDTH+1 cycles.
// No backpressure: start is taken in IDLE or DONE only and silently dropped while busy.
module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, psum;
  logic [WIDTH-1:0] sum_q;
  logic             carry, msb_c;
  logic             cout_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_co;
  logic             accept, last;

  addbit u_addbit (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        accept = bus.start;
        if (bus.start) state_d = SHIFT;
      end
      SHIFT: begin
        last = (cnt == LAST);
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        accept  = bus.start;
        state_d = bus.start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      psum    <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      msb_c   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a  <= bus.a;
        op_b  <= bus.b;
        carry <= bus.cin;
        msb_c <= 1'b0;
        psum  <= '0;
        cnt   <= '0;
      end else if (state_q == SHIFT) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        carry <= bit_co;
        psum  <= {bit_s, psum[WIDTH-1:1]};
        // carry out of bit WIDTH-2 is the carry into the MSB
        if (cnt == PRE_LAST) msb_c <= bit_co;
        if (last) begin
          sum_q  <= {bit_s, psum[WIDTH-1:1]};
          cout_q <= bit_co;
          ovf_q  <= bit_co ^ msb_c;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors push expectations,
// an independent monitor pops and compares on every done pulse.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   busy_run = 0;
  exp_t exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares results and busy-phase length on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        done_count++;
        chk("busy_len", busy_run, W);
        busy_run = 0;
        chk("busy_in_done", {31'd0, bus.busy}, 0);
        chk("pending_expect", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", {24'd0, bus.sum}, {24'd0, e.s});
          chk("cout", {31'd0, bus.cout}, {31'd0, e.c});
          chk("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 1);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, t1, t2;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_sum", {24'd0, bus.sum}, 0);
    chk("rst_cout", {31'd0, bus.cout}, 0);
    chk("rst_ovf", {31'd0, bus.overflow}, 0);
    rst = 1'b0;

    issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); wait_done();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); wait_done();
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); wait_done();
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); wait_done();
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1); wait_done();

    // start during busy is ignored; result of previous op held until done
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_sum", {24'd0, bus.sum}, 32'h00);
    chk("hold_cout", {31'd0, bus.cout}, 1);
    chk("hold_ovf", {31'd0, bus.overflow}, 1);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'h55; bus.b = 8'hAA;
    wait_done();

    // reset in the middle of an operation
    issue(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_done", {31'd0, bus.done}, 0);
    chk("abort_sum", {24'd0, bus.sum}, 0);
    chk("abort_cout", {31'd0, bus.cout}, 0);
    chk("abort_ovf", {31'd0, bus.overflow}, 0);
    rst = 1'b0;
    exp_q.delete();
    dc = done_count;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", done_count, dc);
    chk("idle_after_abort", {31'd0, bus.busy}, 0);

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    begin
      exp_t e;
      e.s = 8'h03; e.c = 1'b0; e.o = 1'b0;
      exp_q.push_back(e);
      wait_done();
      t1 = cyc;
      bus.a = 8'h10; bus.b = 8'h20;
      e.s = 8'h30;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("b2b_busy", {31'd0, bus.busy}, 1);
    bus.start = 1'b0;
    wait_done();
    t2 = cyc;
    chk("b2b_spacing", t2 - t1, W + 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's 1-bit full-adder cell (`addbit`).
- Latches two operands and a carry-in, then feeds one bit pair per clock, LSB first, through a single `addbit` instance.
- Holds the carry in a flop between bits and assembles the sum in a shift register.
- Sits downstream of operand registers; presents a start/busy/done handshake to a controller.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  request a new addition; sampled on rising edge of clk
- a  input  WIDTH  operand A; sampled only when start is accepted
- b  input  WIDTH  operand B; sampled only when start is accepted
- cin  input  1  carry-in; sampled only when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result registers updated this cycle
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - rst dominates start in the same cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load a, b into operand shift regs; cin into carry flop; bit counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge, the `addbit` cell takes opA[0], opB[0] and the carry flop.
  - Its s output shifts into the partial-sum register at the MSB end (register shifts right).
  - Its cout output is written to the carry flop; opA and opB shift right by one.
  - Counter increments.
  - At bit WIDTH-1, capture that bit's carry-in into an MSB-carry flop for overflow.
  - On the edge that processes bit WIDTH-1: sum <= completed partial sum, cout <= cell cout, overflow <= cell cout XOR MSB carry-in; go to DONE.
- DONE:
  - Lasts one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation): next state SHIFT, done still pulses this cycle.
  - Otherwise next state IDLE.
- Outputs:
  - busy=1 exactly when state=SHIFT.
  - done=1 exactly when state=DONE.
  - Both are decoded from registered state; no combinational path from start.
- Latency:
  - start accepted at edge k; busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- Result holding:
  - sum, cout and overflow change only on the completion edge or on reset.
  - They hold the previous result throughout a later SHIFT phase.
- Operand isolation: a, b and cin are ignored outside the accepting edge; changing them mid-operation has no effect.
- start while busy is ignored; no queuing and no error flag.
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum plus carry-out.
  - overflow is meaningful for two's-complement interpretation.
  - The counter is $clog2(WIDTH) bits wide and never wraps within an operation.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse -> busy high for 8 cycles, done pulse on cycle 9; sum=8'h00, cout=0, overflow=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, overflow=0; a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, overflow=1.
- Start a=8'h12, b=8'h34; pulse start again with a=8'hFF, b=8'hFF at busy cycle 3, and change a/b mid-operation -> second start ignored; result sum=8'h46, cout=0; sum holds previous value until done.
- Start a=8'hA5, b=8'h5A; assert rst at busy cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0; no done pulse follows.
- Back-to-back: start held high continuously with a=8'h01, b=8'h02, then a=8'h10, b=8'h20 presented at first done -> done pulses 9 cycles apart; results 8'h03 then 8'h30; busy low only during done cycles.
